// File: rtl/vga_timing_if.sv
// Raster position and sync bundle between the VGA timing generator and its consumers.
interface vga_timing_if;
    logic        en;
    logic [11:0] H_counter;
    logic [9:0]  V_counter;
    logic        hsync;
    logic        vsync;
    logic        display_en;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        pixel_tick;
    logic        line_end;
    logic        frame_end;

    modport master (
        input  en,
        output H_counter, V_counter, hsync, vsync, display_en,
        output pixel_x, pixel_y, pixel_tick, line_end, frame_end
    );

    modport slave (
        output en,
        input  H_counter, V_counter, hsync, vsync, display_en,
        input  pixel_x, pixel_y, pixel_tick, line_end, frame_end
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 raster timing generator at 4x pixel clock: position counters, H/V phase FSMs and
// registered sync, blanking and strobe outputs aligned with the visible counter values.
module vga_timing_gen #(
    parameter int unsigned H_DISP = 2560,
    parameter int unsigned H_FP   = 64,
    parameter int unsigned H_SYNC = 384,
    parameter int unsigned H_BP   = 192,
    parameter int unsigned V_DISP = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 29
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam logic [11:0] HActLast = 12'(H_DISP - 1);
    localparam logic [11:0] HFpLast  = 12'(H_DISP + H_FP - 1);
    localparam logic [11:0] HSynLast = 12'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [11:0] HLast    = 12'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  VActLast = 10'(V_DISP - 1);
    localparam logic [9:0]  VFpLast  = 10'(V_DISP + V_FP - 1);
    localparam logic [9:0]  VSynLast = 10'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic [9:0]  VLast    = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {HAct, HFp, HSyn, HBp} h_state_e;
    typedef enum logic [1:0] {VAct, VFp, VSyn, VBp} v_state_e;

    h_state_e    h_state_q, h_state_d;
    v_state_e    v_state_q, v_state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        at_line_end;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic [9:0] px_q, px_d;
    logic [8:0] py_q, py_d;
    logic       tick_q, tick_d;
    logic       lend_q, lend_d;
    logic       fend_q, fend_d;

    assign at_line_end = (h_cnt_q == HLast);

    // State register: everything advances only on enabled edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_state_q <= HAct;
            v_state_q <= VAct;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            de_q      <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            tick_q    <= 1'b0;
            lend_q    <= 1'b0;
            fend_q    <= 1'b0;
        end else if (vga.en) begin
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            px_q      <= px_d;
            py_q      <= py_d;
            tick_q    <= tick_d;
            lend_q    <= lend_d;
            fend_q    <= fend_d;
        end
    end

    // Next-state: counters and phase FSMs.
    always_comb begin
        h_cnt_d   = at_line_end ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d   = v_cnt_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (at_line_end) begin
            v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
        end
        unique case (h_state_q)
            HAct:    if (h_cnt_q == HActLast) h_state_d = HFp;
            HFp:     if (h_cnt_q == HFpLast)  h_state_d = HSyn;
            HSyn:    if (h_cnt_q == HSynLast) h_state_d = HBp;
            HBp:     if (h_cnt_q == HLast)    h_state_d = HAct;
            default: h_state_d = HAct;
        endcase
        if (at_line_end) begin
            unique case (v_state_q)
                VAct:    if (v_cnt_q == VActLast) v_state_d = VFp;
                VFp:     if (v_cnt_q == VFpLast)  v_state_d = VSyn;
                VSyn:    if (v_cnt_q == VSynLast) v_state_d = VBp;
                VBp:     if (v_cnt_q == VLast)    v_state_d = VAct;
                default: v_state_d = VAct;
            endcase
        end
    end

    // Output decode from next-state values so registered outputs match the registered counters.
    always_comb begin
        hsync_d = (h_state_d != HSyn);
        vsync_d = (v_state_d != VSyn);
        de_d    = (h_state_d == HAct) && (v_state_d == VAct);
        px_d    = de_d ? h_cnt_d[11:2] : 10'd0;
        py_d    = de_d ? v_cnt_d[8:0] : 9'd0;
        tick_d  = de_d && (h_cnt_d[1:0] == 2'd0);
        lend_d  = (h_cnt_d == HLast);
        fend_d  = lend_d && (v_cnt_d == VLast);
    end

    assign vga.H_counter  = h_cnt_q;
    assign vga.V_counter  = v_cnt_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.display_en = de_q;
    assign vga.pixel_x    = px_q;
    assign vga.pixel_y    = py_q;
    assign vga.pixel_tick = tick_q;
    assign vga.line_end   = lend_q;
    assign vga.frame_end  = fend_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-width horizontal timing, shortened vertical frame
// (4 active, 2 FP, 2 sync, 2 BP lines) so a whole frame fits in a short run.
module tb_vga_timing_gen;
    localparam int unsigned VDisp = 4;
    localparam int unsigned VFp   = 2;
    localparam int unsigned VSync = 2;
    localparam int unsigned VBp   = 2;
    localparam int unsigned VTot  = VDisp + VFp + VSync + VBp;
    localparam int unsigned HTot  = 3200;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vga_timing_if vga ();

    vga_timing_gen #(
        .V_DISP (VDisp),
        .V_FP   (VFp),
        .V_SYNC (VSync),
        .V_BP   (VBp)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vga.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the counters show (v,h); an expired budget is reported as a failure.
    task automatic goto_pos(input int v, input int h, input int budget);
        int n;
        n = 0;
        while (!(vga.V_counter == 10'(v) && vga.H_counter == 12'(h)) && n < budget) begin
            tick();
            n++;
        end
        check("reach_pos", {31'd0, (vga.V_counter == 10'(v) && vga.H_counter == 12'(h))}, 1);
    endtask

    initial begin
        int hs_fall, hs_rise, de_fall, ticks, last_px, hs_low, de_high, lends;
        int vs_low, vs_fall_v, vs_fall_h, vs_rise_v, vs_rise_h, de_blank, fends;
        logic prev_hs, prev_de, prev_vs;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        vga.en = 1'b1;
        repeat (5) tick();

        check("rst_h",     32'(vga.H_counter), 0);
        check("rst_v",     32'(vga.V_counter), 0);
        check("rst_hsync", 32'(vga.hsync), 1);
        check("rst_vsync", 32'(vga.vsync), 1);
        check("rst_de",    32'(vga.display_en), 0);
        check("rst_px",    32'(vga.pixel_x), 0);
        check("rst_py",    32'(vga.pixel_y), 0);
        check("rst_tick",  32'(vga.pixel_tick), 0);
        check("rst_lend",  32'(vga.line_end), 0);
        check("rst_fend",  32'(vga.frame_end), 0);

        reset = 1'b1;
        tick();
        check("first_h",  32'(vga.H_counter), 1);
        check("first_de", 32'(vga.display_en), 1);
        check("first_px", 32'(vga.pixel_x), 0);

        // One complete line starting at H=0 of line 1.
        goto_pos(1, 0, HTot);
        hs_fall = -1; hs_rise = -1; de_fall = -1;
        ticks = 0; last_px = -1; hs_low = 0; de_high = 0; lends = 0;
        prev_hs = vga.hsync;
        prev_de = vga.display_en;
        for (int i = 0; i < int'(HTot); i++) begin
            if (prev_hs && !vga.hsync) hs_fall = int'(vga.H_counter);
            if (!prev_hs && vga.hsync) hs_rise = int'(vga.H_counter);
            if (prev_de && !vga.display_en) de_fall = int'(vga.H_counter);
            if (vga.pixel_tick) begin
                ticks++;
                last_px = int'(vga.pixel_x);
            end
            if (!vga.hsync) hs_low++;
            if (vga.display_en) de_high++;
            if (vga.line_end) lends++;
            prev_hs = vga.hsync;
            prev_de = vga.display_en;
            tick();
        end
        check("hs_fall", 32'(hs_fall), 2624);
        check("hs_rise", 32'(hs_rise), 3008);
        check("de_fall", 32'(de_fall), 2560);
        check("ticks",   32'(ticks), 640);
        check("last_px", 32'(last_px), 639);
        check("hs_low",  32'(hs_low), 384);
        check("de_high", 32'(de_high), 2560);
        check("lends",   32'(lends), 1);

        // Frame wrap.
        goto_pos(VTot - 1, HTot - 1, VTot * HTot);
        check("wrap_lend", 32'(vga.line_end), 1);
        check("wrap_fend", 32'(vga.frame_end), 1);
        check("wrap_de",   32'(vga.display_en), 0);
        tick();
        check("wrap_h",     32'(vga.H_counter), 0);
        check("wrap_v",     32'(vga.V_counter), 0);
        check("wrap_de1",   32'(vga.display_en), 1);
        check("wrap_fend0", 32'(vga.frame_end), 0);
        check("wrap_lend0", 32'(vga.line_end), 0);

        // One complete frame from (0,0).
        vs_low = 0; vs_fall_v = -1; vs_fall_h = -1; vs_rise_v = -1; vs_rise_h = -1;
        de_blank = 0; fends = 0;
        prev_vs = vga.vsync;
        for (int i = 0; i < int'(VTot * HTot); i++) begin
            if (prev_vs && !vga.vsync) begin
                vs_fall_v = int'(vga.V_counter);
                vs_fall_h = int'(vga.H_counter);
            end
            if (!prev_vs && vga.vsync) begin
                vs_rise_v = int'(vga.V_counter);
                vs_rise_h = int'(vga.H_counter);
            end
            if (!vga.vsync) vs_low++;
            if (vga.display_en && vga.V_counter >= 10'(VDisp)) de_blank++;
            if (vga.frame_end) fends++;
            prev_vs = vga.vsync;
            tick();
        end
        check("vs_low",    32'(vs_low), 6400);
        check("vs_fall_v", 32'(vs_fall_v), VDisp + VFp);
        check("vs_fall_h", 32'(vs_fall_h), 0);
        check("vs_rise_v", 32'(vs_rise_v), VDisp + VFp + VSync);
        check("vs_rise_h", 32'(vs_rise_h), 0);
        check("de_blank",  32'(de_blank), 0);
        check("fends",     32'(fends), 1);

        // Enable freeze at H=1000 on line 0.
        goto_pos(0, 1000, HTot);
        vga.en = 1'b0;
        repeat (50) tick();
        check("frz_h",     32'(vga.H_counter), 1000);
        check("frz_v",     32'(vga.V_counter), 0);
        check("frz_de",    32'(vga.display_en), 1);
        check("frz_px",    32'(vga.pixel_x), 250);
        check("frz_tick",  32'(vga.pixel_tick), 1);
        check("frz_hsync", 32'(vga.hsync), 1);
        check("frz_vsync", 32'(vga.vsync), 1);
        vga.en = 1'b1;
        tick();
        check("res_h",    32'(vga.H_counter), 1001);
        check("res_tick", 32'(vga.pixel_tick), 0);
        check("res_px",   32'(vga.pixel_x), 250);

        // Asynchronous reset during hsync, between edges.
        goto_pos(0, 2700, HTot);
        check("pre_hsync", 32'(vga.hsync), 0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_hsync", 32'(vga.hsync), 1);
        check("arst_h",     32'(vga.H_counter), 0);
        check("arst_v",     32'(vga.V_counter), 0);
        check("arst_de",    32'(vga.display_en), 0);
        tick();
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
